// File: rtl/dds_voice_sequencer_pkg.sv
// Shared types and width helpers for the DDS voice sequencer.
package dds_seq_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Width of a voice index.
  function automatic int vidx_w(input int voices);
    return $clog2(voices);
  endfunction

  // Mix width: one extra bit per doubling of the voice count, so a full
  // frame of extreme samples can never overflow.
  function automatic int mix_w(input int sine_w, input int voices);
    return sine_w + $clog2(voices);
  endfunction

endpackage

// File: rtl/dds_voice_sequencer_if.sv
// Bus between the DDS voice sequencer and its neighbours: note front end
// (tick/config), shared sine table (request/response) and mix consumer.
interface dds_voice_sequencer_if #(
  parameter int VOICES  = 8,
  parameter int PHASE_W = 32,
  parameter int SINE_W  = 32
);
  import dds_seq_pkg::*;

  localparam int VIDX_W = vidx_w(VOICES);
  localparam int MIX_W  = mix_w(SINE_W, VOICES);

  logic                TICK;
  logic                CFG_WE;
  logic [VIDX_W-1:0]   CFG_VOICE;
  logic [PHASE_W-1:0]  CFG_ADDER;
  logic                CFG_GATE;
  logic                CFG_PHASE_CLR;
  logic [PHASE_W-1:0]  DDS;
  logic                DDS_VALID;
  logic [SINE_W-1:0]   SINE_IN;
  logic [MIX_W-1:0]    MIX_OUT;
  logic                MIX_VALID;
  logic                BUSY;
  logic                OVERRUN;

  // Environment side: strobes, config and table data in; requests and mix out.
  modport master (
    output TICK, CFG_WE, CFG_VOICE, CFG_ADDER, CFG_GATE, CFG_PHASE_CLR, SINE_IN,
    input  DDS, DDS_VALID, MIX_OUT, MIX_VALID, BUSY, OVERRUN
  );

  // Sequencer side.
  modport slave (
    input  TICK, CFG_WE, CFG_VOICE, CFG_ADDER, CFG_GATE, CFG_PHASE_CLR, SINE_IN,
    output DDS, DDS_VALID, MIX_OUT, MIX_VALID, BUSY, OVERRUN
  );

endinterface

// File: rtl/dds_voice_sequencer_phase_bank.sv
// Per-voice phase / adder / gate register file. One config write port and
// one read-and-advance port; the read is combinational from the current
// registers, so a same-cycle config write never affects the voice being read.
module dds_phase_bank
  import dds_seq_pkg::*;
#(
  parameter  int VOICES  = 8,
  parameter  int PHASE_W = 32,
  localparam int VIDX_W  = vidx_w(VOICES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we_i,
  input  logic [VIDX_W-1:0]  cfg_voice_i,
  input  logic [PHASE_W-1:0] cfg_adder_i,
  input  logic               cfg_gate_i,
  input  logic               cfg_phase_clr_i,
  input  logic               adv_i,
  input  logic [VIDX_W-1:0]  rd_idx_i,
  output logic [PHASE_W-1:0] rd_phase_o,
  output logic               rd_gate_o
);

  logic [VOICES-1:0][PHASE_W-1:0] phase_q, phase_d;
  logic [VOICES-1:0][PHASE_W-1:0] adder_q, adder_d;
  logic [VOICES-1:0]              gate_q,  gate_d;

  assign rd_phase_o = phase_q[rd_idx_i];
  assign rd_gate_o  = gate_q[rd_idx_i];

  // Next state: advance the read voice if sounding, then apply any config
  // write on top (a phase clear wins over the advance).
  always_comb begin
    phase_d = phase_q;
    adder_d = adder_q;
    gate_d  = gate_q;
    if (adv_i && gate_q[rd_idx_i]) begin
      phase_d[rd_idx_i] = phase_q[rd_idx_i] + adder_q[rd_idx_i];
    end
    if (cfg_we_i) begin
      adder_d[cfg_voice_i] = cfg_adder_i;
      gate_d[cfg_voice_i]  = cfg_gate_i;
      if (cfg_phase_clr_i) begin
        phase_d[cfg_voice_i] = '0;
      end
    end
  end

  // Register file update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      adder_q <= '0;
      gate_q  <= '0;
    end else begin
      phase_q <= phase_d;
      adder_q <= adder_d;
      gate_q  <= gate_d;
    end
  end

endmodule

// File: rtl/dds_voice_sequencer.sv
// Time-multiplexes one shared sine-table lookup across VOICES voices. A TICK
// starts a frame: one voice phase is issued per cycle, the returned samples
// of sounding voices are summed, and one mix is emitted per frame.
module dds_voice_sequencer
  import dds_seq_pkg::*;
#(
  parameter int VOICES    = 8,
  parameter int PHASE_W   = 32,
  parameter int SINE_W    = 32,
  parameter int TABLE_LAT = 1
) (
  input logic                  CLK,
  input logic                  RESET,
  dds_voice_sequencer_if.slave bus
);

  localparam int VIDX_W = vidx_w(VOICES);
  localparam int MIX_W  = mix_w(SINE_W, VOICES);
  localparam int EXT_W  = MIX_W - SINE_W;

  seq_state_e              state_q;
  logic [VIDX_W-1:0]       idx_q;
  logic [PHASE_W-1:0]      dds_q;
  logic                    dds_vld_q;
  // Tag pipeline: stage 0 lines up with DDS_VALID, stage TABLE_LAT with the
  // matching SINE_IN.
  logic [TABLE_LAT:0]      tag_vld_q;
  logic [TABLE_LAT:0]      tag_gate_q;
  logic signed [MIX_W-1:0] acc_q, acc_d;
  logic signed [MIX_W-1:0] mix_q;
  logic signed [MIX_W-1:0] sine_ext;
  logic                    mix_vld_q;
  logic                    busy_q;
  logic                    ovr_q;
  logic                    issue;
  logic                    in_flight;
  logic [PHASE_W-1:0]      rd_phase;
  logic                    rd_gate;

  assign issue = (state_q == ST_ISSUE);

  dds_phase_bank #(
    .VOICES  (VOICES),
    .PHASE_W (PHASE_W)
  ) u_bank (
    .clk             (CLK),
    .rst_n           (RESET),
    .cfg_we_i        (bus.CFG_WE),
    .cfg_voice_i     (bus.CFG_VOICE),
    .cfg_adder_i     (bus.CFG_ADDER),
    .cfg_gate_i      (bus.CFG_GATE),
    .cfg_phase_clr_i (bus.CFG_PHASE_CLR),
    .adv_i           (issue),
    .rd_idx_i        (idx_q),
    .rd_phase_o      (rd_phase),
    .rd_gate_o       (rd_gate)
  );

  assign sine_ext = $signed({{EXT_W{bus.SINE_IN[SINE_W-1]}}, bus.SINE_IN});

  // Accumulate the sample landing this cycle if its voice was sounding.
  always_comb begin
    acc_d = acc_q;
    if (tag_vld_q[TABLE_LAT] && tag_gate_q[TABLE_LAT]) begin
      acc_d = acc_q + sine_ext;
    end
  end

  // Requests still more than one cycle away from their sample; once none
  // remain, the next cycle is the last landing and can close the frame.
  always_comb begin
    in_flight = 1'b0;
    for (int k = 0; k < TABLE_LAT - 1; k++) begin
      in_flight = in_flight | tag_vld_q[k];
    end
  end

  // Frame FSM with registered outputs, tag pipeline and accumulator.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      dds_q      <= '0;
      dds_vld_q  <= 1'b0;
      tag_vld_q  <= '0;
      tag_gate_q <= '0;
      acc_q      <= '0;
      mix_q      <= '0;
      mix_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      dds_vld_q  <= 1'b0;
      mix_vld_q  <= 1'b0;
      ovr_q      <= bus.TICK && (state_q != ST_IDLE);
      tag_vld_q  <= {tag_vld_q[TABLE_LAT-1:0], 1'b0};
      tag_gate_q <= {tag_gate_q[TABLE_LAT-1:0], 1'b0};
      acc_q      <= acc_d;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.TICK) begin
            state_q <= ST_ISSUE;
            idx_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          dds_q      <= rd_phase;
          dds_vld_q  <= 1'b1;
          tag_vld_q  <= {tag_vld_q[TABLE_LAT-1:0], 1'b1};
          tag_gate_q <= {tag_gate_q[TABLE_LAT-1:0], rd_gate};
          if (idx_q == VIDX_W'(VOICES - 1)) begin
            state_q <= ST_DRAIN;
          end else begin
            idx_q <= idx_q + VIDX_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!in_flight) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          mix_q     <= acc_d;
          mix_vld_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.DDS       = dds_q;
  assign bus.DDS_VALID = dds_vld_q;
  assign bus.MIX_OUT   = mix_q;
  assign bus.MIX_VALID = mix_vld_q;
  assign bus.BUSY      = busy_q;
  assign bus.OVERRUN   = ovr_q;

endmodule

// File: tb/tb_dds_voice_sequencer.sv
// Scoreboard bench for dds_voice_sequencer: a reference model of the voice
// bank predicts every table request and every frame mix at TICK time; a
// monitor pops and compares them as the DUT produces them.
module tb_dds_voice_sequencer;

  localparam int VOICES    = 8;
  localparam int PHASE_W   = 32;
  localparam int SINE_W    = 32;
  localparam int TABLE_LAT = 1;
  localparam int VIDX_W    = $clog2(VOICES);
  localparam int MIX_W     = SINE_W + VIDX_W;
  localparam int LAT       = VOICES + TABLE_LAT + 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  dds_voice_sequencer_if #(.VOICES(VOICES), .PHASE_W(PHASE_W), .SINE_W(SINE_W)) bus ();

  dds_voice_sequencer #(
    .VOICES(VOICES), .PHASE_W(PHASE_W), .SINE_W(SINE_W), .TABLE_LAT(TABLE_LAT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [PHASE_W-1:0] phase_m [VOICES];
  logic [PHASE_W-1:0] adder_m [VOICES];
  logic               gate_m  [VOICES];
  logic [SINE_W-1:0]  tbl_const = '0;
  logic               tbl_mix   = 1'b0;

  typedef struct {
    logic [MIX_W-1:0] mix;
    int               cyc;
  } mix_exp_t;

  mix_exp_t           mix_q [$];
  logic [PHASE_W-1:0] dds_q [$];
  int cyc        = 0;
  int last_acc   = -1000;
  int exp_ovr    = 0;
  int ovr_seen   = 0;
  int mix_seen   = 0;
  int mix_pushed = 0;
  logic [MIX_W-1:0] last_mix = '0;
  mix_exp_t mon_e;

  function automatic logic [SINE_W-1:0] tbl_fn(input logic [PHASE_W-1:0] ph);
    return tbl_const ^ (tbl_mix ? {24'h0, ph[31:24]} : 32'h0);
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Shared sine table: answers one cycle after each request, garbage otherwise.
  logic               pend_v   = 1'b0;
  logic [PHASE_W-1:0] pend_dds = '0;
  always @(negedge CLK) begin
    if (!RESET) begin
      pend_v      = 1'b0;
      bus.SINE_IN = 32'h5A5A_5A5A;
    end else begin
      bus.SINE_IN = pend_v ? tbl_fn(pend_dds) : 32'h5A5A_5A5A;
      pend_v      = bus.DDS_VALID;
      pend_dds    = bus.DDS;
    end
  end

  // Monitor: compare requests and mixes against the scoreboard.
  always @(negedge CLK) begin
    if (RESET) begin
      if (bus.DDS_VALID) begin
        if (dds_q.size() > 0) check_eq("dds_phase", bus.DDS, dds_q.pop_front());
        else                  check_eq("dds_unexpected", bus.DDS_VALID, 1'b0);
      end
      if (bus.MIX_VALID) begin
        mix_seen++;
        last_mix = bus.MIX_OUT;
        if (mix_q.size() > 0) begin
          mon_e = mix_q.pop_front();
          check_eq("mix_out", bus.MIX_OUT, mon_e.mix);
          check_eq("mix_latency", cyc - mon_e.cyc, LAT);
        end else begin
          check_eq("mix_unexpected", bus.MIX_VALID, 1'b0);
        end
      end
      if (bus.OVERRUN) ovr_seen++;
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic cfg(input int v, input logic [PHASE_W-1:0] add, input logic g, input logic clr);
    bus.CFG_WE        = 1'b1;
    bus.CFG_VOICE     = v[VIDX_W-1:0];
    bus.CFG_ADDER     = add;
    bus.CFG_GATE      = g;
    bus.CFG_PHASE_CLR = clr;
    adder_m[v] = add;
    gate_m[v]  = g;
    if (clr) phase_m[v] = '0;
    step(1);
    bus.CFG_WE        = 1'b0;
    bus.CFG_PHASE_CLR = 1'b0;
  endtask

  task automatic tick();
    mix_exp_t e;
    logic signed [MIX_W-1:0] acc;
    logic [SINE_W-1:0] s;
    bus.TICK = 1'b1;
    if (cyc - last_acc >= LAT) begin
      last_acc = cyc;
      acc = '0;
      for (int v = 0; v < VOICES; v++) begin
        dds_q.push_back(phase_m[v]);
        if (gate_m[v]) begin
          s = tbl_fn(phase_m[v]);
          acc = acc + $signed({{(MIX_W-SINE_W){s[SINE_W-1]}}, s});
          phase_m[v] = phase_m[v] + adder_m[v];
        end
      end
      e.mix = acc;
      e.cyc = cyc;
      mix_q.push_back(e);
      mix_pushed++;
    end else begin
      exp_ovr++;
    end
    step(1);
    bus.TICK = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((mix_q.size() > 0 || dds_q.size() > 0) && n < budget) begin
      step(1);
      n++;
    end
    if (mix_q.size() > 0 || dds_q.size() > 0) check_eq("drain_timeout", mix_q.size(), 0);
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.TICK = 1'b0; bus.CFG_WE = 1'b0; bus.CFG_VOICE = '0; bus.CFG_ADDER = '0;
    bus.CFG_GATE = 1'b0; bus.CFG_PHASE_CLR = 1'b0;
    for (int v = 0; v < VOICES; v++) begin
      phase_m[v] = '0; adder_m[v] = '0; gate_m[v] = 1'b0;
    end

    // Reset held: stimulus must be ignored, outputs stay zero
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      bus.TICK = i[0]; bus.CFG_WE = 1'b1; bus.CFG_VOICE = i[VIDX_W-1:0];
      bus.CFG_ADDER = 32'hFFFF_FFFF; bus.CFG_GATE = 1'b1;
      @(negedge CLK);
      check_eq("rst_busy", bus.BUSY, 1'b0);
      check_eq("rst_mix_valid", bus.MIX_VALID, 1'b0);
    end
    check_eq("rst_dds", bus.DDS, 32'h0);
    check_eq("rst_dds_valid", bus.DDS_VALID, 1'b0);
    check_eq("rst_mix_out", bus.MIX_OUT, '0);
    check_eq("rst_overrun", bus.OVERRUN, 1'b0);
    @(posedge CLK); #1;
    bus.TICK = 1'b0; bus.CFG_WE = 1'b0; bus.CFG_GATE = 1'b0; bus.CFG_ADDER = '0;
    RESET = 1'b1;
    step(12);
    check_eq("idle_busy", bus.BUSY, 1'b0);
    check_eq("idle_no_mix", mix_seen, 0);

    // Frame with no config: reset values of the bank must give silence
    tbl_const = 32'd77;
    tick();
    drain(40);
    check_eq("silent_mix", last_mix, '0);

    // Single voice, constant table
    cfg(0, 32'h0100_0000, 1'b1, 1'b1);
    tbl_const = 32'd100;
    tick();
    drain(40);
    check_eq("single_mix", last_mix, 35'd100);
    tick();
    drain(40);

    // All voices at full-scale positive / negative
    for (int v = 0; v < VOICES; v++) cfg(v, $urandom, 1'b1, 1'b0);
    tbl_const = 32'h7FFF_FFFF;
    tick();
    drain(40);
    check_eq("max_pos_mix", last_mix, 35'h3_FFFF_FFF8);
    tbl_const = 32'h8000_0000;
    tick();
    drain(40);
    check_eq("max_neg_mix", last_mix, 35'h4_0000_0000);

    // Phase wrap on voice 1, frozen gated-off voice 3, phase-dependent table
    cfg(1, 32'h8000_0000, 1'b1, 1'b1);
    cfg(3, 32'h1234_5678, 1'b1, 1'b1);
    tbl_const = 32'h0000_1000;
    tbl_mix   = 1'b1;
    tick();
    drain(40);
    cfg(3, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    drain(40);
    tick();
    drain(40);

    // TICK inside a frame and on its last busy cycle is an overrun;
    // TICK on the MIX_VALID cycle starts the next frame
    tick();
    step(2);
    tick();
    drain(40);
    tick();
    step(9);
    tick();
    tick();
    drain(40);
    check_eq("overrun_count", ovr_seen, exp_ovr);
    check_eq("overrun_expected", exp_ovr, 2);

    // Config write to voice 2 during its own issue cycle
    tick();
    step(2);
    cfg(2, 32'h0000_0100, 1'b1, 1'b0);
    drain(40);
    tick();
    drain(40);
    tick();
    drain(40);

    // Reset in the middle of a frame
    tick();
    step(4);
    RESET = 1'b0;
    mix_pushed -= mix_q.size();
    mix_q.delete();
    dds_q.delete();
    last_acc = -1000;
    for (int v = 0; v < VOICES; v++) begin
      phase_m[v] = '0; adder_m[v] = '0; gate_m[v] = 1'b0;
    end
    @(negedge CLK);
    check_eq("midrst_busy", bus.BUSY, 1'b0);
    check_eq("midrst_mix_valid", bus.MIX_VALID, 1'b0);
    check_eq("midrst_dds_valid", bus.DDS_VALID, 1'b0);
    check_eq("midrst_dds", bus.DDS, 32'h0);
    step(2);
    RESET = 1'b1;
    step(20);
    cfg(0, 32'h0100_0000, 1'b1, 1'b0);
    cfg(5, 32'h0200_0000, 1'b1, 1'b0);
    tbl_mix = 1'b0;
    tbl_const = 32'hFFFF_FFF6;
    tick();
    drain(40);
    check_eq("post_rst_mix", last_mix, 35'h7_FFFF_FFEC);
    tick();
    drain(40);

    check_eq("mix_count", mix_seen, mix_pushed);
    check_eq("final_busy", bus.BUSY, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
